fwrite_buffer: RTL and testbench
================================

Name: fwrite_buffer

Overview:
- Receive-side counterpart of the ESP fread loader: collects a byte stream arriving from the UART receiver into on-chip block RAM.
- When the block is full or a flush is requested, issues a write request to the ESP SPI bridge for file FILE_ID.
- Then streams the buffered bytes out on the bridge's write-data stream interface.
- Sits between uart_rx and the SPI/ESP command arbiter.

Parameters:
- DEPTH_LOG2, 10, log2 of buffer size in bytes (default 1024).
- FILE_ID, 32'hDABBAD00, ESP file identifier driven on req_fid.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure possible
- flush  input  1  one-cycle strobe: send partial buffer now
- req_valid  output  1  write request valid
- req_ready  input  1  bridge accepts request
- req_fid  output  32  file id, constant FILE_ID
- req_len  output  DEPTH_LOG2+1  byte count of this request
- wr_data  output  8  write-data byte
- wr_valid  output  1  wr_data valid
- wr_ready  input  1  bridge consumes byte
- busy  output  1  high in REQ or SEND
- overflow  output  1  sticky: a byte was dropped
- blocks_sent  output  16  count of completed requests

Behaviour:
- Reset values (async, rst_n low): state=FILL, count=0, rd_ptr=0, req_valid=0, wr_valid=0, wr_data=0, overflow=0, blocks_sent=0. Reset is honoured in any state; a transfer in flight is abandoned and RAM contents are don't-care.
- Storage: single-port-write / registered-read RAM of 2^DEPTH_LOG2 x 8.
- count width is DEPTH_LOG2+1 and saturates at 2^DEPTH_LOG2.
- State FILL:
  - rx_valid writes mem[count[DEPTH_LOG2-1:0]] <= rx_data; count++.
  - Go to REQ on the cycle after count reaches 2^DEPTH_LOG2, or on flush with count>0.
  - Same-cycle rx_valid and flush: store the byte first; it is included in the request.
  - flush with count==0 is ignored.
- State REQ:
  - req_valid=1 and req_len=count, both held stable until req_valid & req_ready.
  - On that handshake go to SEND with rd_ptr=0.
  - req_ready while req_valid=0 has no effect.
- State SEND (read-ahead stage, 1 byte/cycle sustained):
  - Load condition: wr_valid==0 or (wr_valid & wr_ready).
  - If the load condition holds and rd_ptr<count: wr_data<=mem[rd_ptr], wr_valid<=1, rd_ptr++.
  - If the load condition holds and rd_ptr==count: wr_valid<=0; state<=FILL; count<=0; blocks_sent++ (wraps 16'hFFFF->0).
  - wr_data is held while wr_valid & ~wr_ready.
  - First wr_valid rises 1 cycle after the req handshake.
- Drop rule: rx_valid outside FILL, or in FILL with count already 2^DEPTH_LOG2 (only possible in the transition cycle), drops the byte and sets overflow=1 until reset.
- flush outside FILL is ignored (not queued).
- busy = (state==REQ) | (state==SEND).

Decomposition:
- Shared package fread_pkg: state encoding localparams (ST_FILL, ST_REQ, ST_SEND) and default FILE_ID constant; the fread loader uses the same FILE_ID.
- One sub-module, fwrite_ram: 2^DEPTH_LOG2 x 8 memory, synchronous write, registered read, so it maps to iCE40 EBR.

Test Plan:
- DEPTH_LOG2=4: 16 rx strobes 0x00..0x0F, req_ready=1, wr_ready=1 -> req_len=16; wr_data 0x00..0x0F on 16 consecutive cycles; blocks_sent=1; busy falls.
- 5 bytes 0xA0..0xA4 then flush -> req_len=5; exactly 5 wr beats 0xA0..0xA4; state back to FILL, count=0.
- wr_ready toggled 1/0 every cycle during SEND -> every byte is presented until accepted; no byte repeated or skipped; wr_data stable while stalled.
- rx_valid strobes while busy (req_ready held low 20 cycles) -> overflow=1; dropped bytes absent from the following block.
- rx_valid and flush in the same cycle with count=2 -> req_len=3 and the last byte is included; flush with count=0 -> req_valid stays 0.
- rst_n pulsed low mid-SEND after 3 beats -> all outputs return to reset values asynchronously; the next 16 bytes form a clean block with blocks_sent=1.

Source files
------------

// File: rtl/fread_pkg.sv
// Shared definitions for the ESP file loader and the receive-side write buffer:
// state encoding and the file identifier both blocks agree on.
package fread_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FILL = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_SEND = 2'd2;

  localparam logic [31:0] FILE_ID_DEFAULT = 32'hDABBAD00;

endpackage

// File: rtl/fwrite_ram.sv
// Byte-wide buffer memory: synchronous write, registered read with read enable,
// shaped so it maps onto an iCE40 EBR.
module fwrite_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Write port.
  // NOTE: the array has no reset; block RAM cannot be cleared in one cycle and
  // every location is written before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; the output register holds its value while re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fwrite_buffer.sv
// Collects UART bytes into a buffer, requests a file write from the ESP SPI
// bridge when full or flushed, then streams the buffered bytes to the bridge.
module fwrite_buffer
  import fread_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] FILE_ID    = FILE_ID_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  flush,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [31:0]           req_fid,
  output logic [DEPTH_LOG2:0]   req_len,
  output logic [7:0]            wr_data,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  overflow,
  output logic [15:0]           blocks_sent
);

  localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};

  state_t              state, state_nxt;
  logic [DEPTH_LOG2:0] count;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                full, accept, load, ram_re, done;

  // Buffer is full once count reaches the saturation value.
  assign full   = (count == CNT_FULL);
  // A byte is stored only while filling and there is room for it.
  assign accept = rx_valid && (state == ST_FILL) && !full;
  // Output stage may take a new byte when empty or when its byte is consumed.
  assign load   = (state == ST_SEND) && (!wr_valid || wr_ready);
  assign ram_re = load && (rd_ptr < count);
  assign done   = load && !(rd_ptr < count);

  fwrite_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (count[DEPTH_LOG2-1:0]),
    .wdata (rx_data),
    .re    (ram_re),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (wr_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FILL;
    else        state <= state_nxt;
  end

  // Next-state logic; a byte arriving with flush is counted before deciding.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: if (full || (flush && (count != '0 || accept))) state_nxt = ST_REQ;
      ST_REQ:  if (req_ready) state_nxt = ST_SEND;
      ST_SEND: if (done)      state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs; req_len is count, which cannot change outside FILL.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      ST_REQ:  begin req_valid = 1'b1; busy = 1'b1; end
      ST_SEND: busy = 1'b1;
      default: ;
    endcase
  end

  assign req_fid = FILE_ID;
  assign req_len = count;

  // Datapath: fill counter, read pointer, output valid, status counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_valid    <= 1'b0;
      overflow    <= 1'b0;
      blocks_sent <= '0;
    end else begin
      if (accept)    count <= count + CNT_ONE;
      else if (done) count <= '0;

      if ((state == ST_REQ) && req_ready) rd_ptr <= '0;
      else if (ram_re)                    rd_ptr <= rd_ptr + CNT_ONE;

      if (ram_re)    wr_valid <= 1'b1;
      else if (done) wr_valid <= 1'b0;

      if (rx_valid && !accept) overflow <= 1'b1;

      if (done) blocks_sent <= blocks_sent + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwrite_buffer.sv
// Directed bench for fwrite_buffer with a 16-byte buffer.
module tb_fwrite_buffer;

  localparam int DL2 = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     rx_data = '0;
  logic           rx_valid = 1'b0;
  logic           flush = 1'b0;
  logic           req_valid;
  logic           req_ready = 1'b0;
  logic [31:0]    req_fid;
  logic [DL2:0]   req_len;
  logic [7:0]     wr_data;
  logic           wr_valid;
  logic           wr_ready = 1'b0;
  logic           busy;
  logic           overflow;
  logic [15:0]    blocks_sent;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  logic [7:0] beats[$];
  int         beat_cyc[$];
  int         req_lens[$];
  bit         stall_chk = 1'b0;
  bit         held = 1'b0;
  logic [7:0] held_data = '0;

  fwrite_buffer #(.DEPTH_LOG2(DL2), .FILE_ID(32'hDABBAD00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fid     (req_fid),
    .req_len     (req_len),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .busy        (busy),
    .overflow    (overflow),
    .blocks_sent (blocks_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: records handshakes and checks data is held while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (stall_chk && held && wr_valid) check("stall_hold", {24'd0, wr_data}, {24'd0, held_data});
      held      = wr_valid && !wr_ready;
      held_data = wr_data;
      if (wr_valid && wr_ready) begin
        beats.push_back(wr_data);
        beat_cyc.push_back(cycle);
      end
      if (req_valid && req_ready) req_lens.push_back(int'(req_len));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic with_flush);
    rx_data  = b;
    rx_valid = 1'b1;
    flush    = with_flush;
    tick();
    rx_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic clear_log();
    beats.delete();
    beat_cyc.delete();
    req_lens.delete();
  endtask

  // Wait for busy to rise (if not already) and then fall, both bounded.
  task automatic run_block(input string tag, input logic toggle_ready);
    int n;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 200) begin
      if (toggle_ready) wr_ready = ~wr_ready;
      tick();
      n++;
    end
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_beats(input string tag, input int n, input logic [7:0] base);
    logic [7:0] got;
    check({tag, "_nbeats"}, beats.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < beats.size()) ? beats[i] : 8'hxx;
      check($sformatf("%s_beat%0d", tag, i), {24'd0, got}, {24'd0, base + 8'(i)});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"},   {31'd0, req_valid}, 32'd0);
    check({tag, "_wr_valid"},    {31'd0, wr_valid},  32'd0);
    check({tag, "_wr_data"},     {24'd0, wr_data},   32'd0);
    check({tag, "_overflow"},    {31'd0, overflow},  32'd0);
    check({tag, "_blocks_sent"}, {16'd0, blocks_sent}, 32'd0);
    check({tag, "_busy"},        {31'd0, busy},      32'd0);
    check({tag, "_req_len"},     {27'd0, req_len},   32'd0);
  endtask

  initial begin
    // Reset state.
    #2;
    check_reset_outputs("rst");
    check("rst_fid", req_fid, 32'hDABBAD00);
    #10 rst_n = 1'b1;
    tick();

    // Full block of 16 bytes, bridge always ready.
    req_ready = 1'b1;
    wr_ready  = 1'b1;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    run_block("t1", 1'b0);
    check("t1_nreq", req_lens.size(), 1);
    check("t1_req_len", (req_lens.size() > 0) ? req_lens[0] : -1, 16);
    check_beats("t1", 16, 8'h00);
    check("t1_consecutive", (beat_cyc.size() == 16) ? beat_cyc[15] - beat_cyc[0] : -1, 15);
    check("t1_blocks", {16'd0, blocks_sent}, 32'd1);

    // Partial block of 5 bytes then flush.
    clear_log();
    for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i), 1'b0);
    do_flush();
    run_block("t2", 1'b0);
    check("t2_req_len", (req_lens.size() > 0) ? req_lens[0] : -1, 5);
    check_beats("t2", 5, 8'hA0);
    check("t2_count_zero", {27'd0, req_len}, 32'd0);
    check("t2_blocks", {16'd0, blocks_sent}, 32'd2);

    // Write-side back-pressure toggled every cycle.
    clear_log();
    for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i), 1'b0);
    do_flush();
    stall_chk = 1'b1;
    run_block("t3", 1'b1);
    stall_chk = 1'b0;
    wr_ready  = 1'b1;
    check("t3_req_len", (req_lens.size() > 0) ? req_lens[0] : -1, 6);
    check_beats("t3", 6, 8'h30);

    // Bytes arriving while the request is stalled are dropped.
    clear_log();
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_byte(8'h50 + 8'(i), 1'b0);
    do_flush();
    check("t4_overflow_pre", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 0) send_byte(8'hEE, 1'b0);
      else tick();
    end
    check("t4_req_valid", {31'd0, req_valid}, 32'd1);
    check("t4_req_len_held", {27'd0, req_len}, 32'd3);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    req_ready = 1'b1;
    run_block("t4", 1'b0);
    check_beats("t4", 3, 8'h50);
    check("t4_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Byte and flush in the same cycle, then flush on an empty buffer.
    clear_log();
    send_byte(8'h60, 1'b0);
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b1);
    run_block("t5", 1'b0);
    check("t5_req_len", (req_lens.size() > 0) ? req_lens[0] : -1, 3);
    check_beats("t5", 3, 8'h60);
    do_flush();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_empty_flush_req%0d", i), {31'd0, req_valid}, 32'd0);
      tick();
    end
    check("t5_empty_flush_nreq", req_lens.size(), 1);

    // Reset in the middle of a transfer, then a clean block.
    clear_log();
    for (int i = 0; i < 16; i++) send_byte(8'h70 + 8'(i), 1'b0);
    begin
      int n;
      n = 0;
      while (beats.size() < 3 && n < 50) begin tick(); n++; end
      check("t6_reach_send", {31'd0, busy}, 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    #2 rst_n = 1'b1;
    tick();
    clear_log();
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i), 1'b0);
    run_block("t6", 1'b0);
    check("t6_req_len", (req_lens.size() > 0) ? req_lens[0] : -1, 16);
    check_beats("t6", 16, 8'h80);
    check("t6_blocks", {16'd0, blocks_sent}, 32'd1);
    check("t6_overflow", {31'd0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
